ahb_ws_ram: RTL and testbench
=============================

AHB_WS_RAM -- requirements
Module: ahb_ws_ram

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address width (memory = 2^AW x 32-bit words).
REQ-002 SHALL have parameter WS, default 1, meaning wait states inserted per OKAY transfer (legal 0..7).
REQ-003 SHALL have port HCLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port HRESETn, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port HSEL, input, 1, slave select.
REQ-006 SHALL have port HADDR, input, 32, byte address; only bits [AW+1:0] are used.
REQ-007 SHALL have port HTRANS, input, 2, transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 SHALL have port HWRITE, input, 1, 1=write.
REQ-009 SHALL have port HSIZE, input, 3, 0=byte, 1=halfword, 2=word.
REQ-010 SHALL have port HREADY, input, 1, bus-level ready.
REQ-011 SHALL have port HWDATA, input, 32, write data (data phase).
REQ-012 SHALL have port HRDATA, output, 32, read data.
REQ-013 SHALL have port HREADYOUT, output, 1, slave ready.
REQ-014 SHALL have port HRESP, output, 1, 0=OKAY, 1=ERROR.

Function
REQ-015 SHALL accept an address phase only when HSEL & HREADY & HTRANS[1]; on acceptance it latches HADDR[AW+1:0], HWRITE and HSIZE.
REQ-016 SHALL treat IDLE/BUSY, or HSEL=0 with HREADY=1, as no transfer: the next cycle has HREADYOUT=1, HRESP=0, and no memory access.
REQ-017 SHALL use FSM states IDLE, WAIT, LAST, ERR1, ERR2.
REQ-018 On an accepted legal transfer the FSM SHALL enter WAIT with the 3-bit counter loaded to WS-1 if WS>0, else LAST.
REQ-019 WAIT SHALL drive HREADYOUT=0 and decrement the counter; at counter 0 it SHALL go to LAST.
REQ-020 LAST SHALL drive HREADYOUT=1, HRESP=0; the next state is WAIT, LAST, ERR1 or IDLE according to any new address phase accepted in the same cycle (pipelined back-to-back).
REQ-021 An OKAY transfer SHALL therefore complete in exactly WS+1 data-phase cycles.
REQ-022 An illegal transfer SHALL go to ERR1; illegal means HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
REQ-023 ERR1 SHALL drive HREADYOUT=0, HRESP=1, then go to ERR2.
REQ-024 ERR2 SHALL drive HREADYOUT=1, HRESP=1, and accept a new address phase like LAST.
REQ-025 No memory write SHALL occur for an illegal transfer.
REQ-026 A write SHALL update memory word HADDR[AW+1:2] only in the LAST cycle, from HWDATA.
REQ-027 Write byte lanes SHALL be: byte, lane = addr[1:0]; halfword, lanes {addr[1],0} and {addr[1],1}; word, all 4 lanes; unselected lanes SHALL be unchanged.
REQ-028 On a read, HRDATA SHALL present the full 32-bit word at the latched word address in LAST; the master selects lanes.
REQ-029 HRDATA SHALL be 32'h0 whenever the current data phase is not a read in LAST.
REQ-030 A read immediately following a write to the same word SHALL return the newly written data, with no extra stall.
REQ-031 A new accepted address phase SHALL NOT disturb the latched control of the transfer still in its data phase.
REQ-032 Address bits above AW+1 SHALL be ignored (aliasing); wrap-around at 2^AW words is inherent.

Reset
REQ-033 While HRESETn=0 the FSM SHALL be IDLE, the counter 0, the latched control cleared, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-034 Reset asserted mid-transfer SHALL abort it with no partial memory write; memory contents are not initialised or cleared by reset.

Verification
REQ-035 WS=1: word write 32'hCAFEBABE at 0x10, then word read of 0x10 -> each data phase has 1 cycle HREADYOUT=0 then 1 cycle HREADYOUT=1; read returns 32'hCAFEBABE.
REQ-036 WS=0: word write 0x11223344 at 0x20; byte write 0xAA to 0x21; halfword write 0x5566xxxx (upper lanes) to 0x22; then read 0x20 -> 32'h5566AA44, no stall cycles.
REQ-037 Halfword transfer to 0x03 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); a following read of word 0x00 is unchanged.
REQ-038 WS=2: back-to-back NONSEQ write then read to the same word, pipelined -> the read returns the written data; total 6 data-phase cycles.
REQ-039 Apply HRESETn=0 during a WAIT of a write to 0x40 (prior value 0x0) -> HREADYOUT=1 immediately; a later read of 0x40 returns 0x0.
REQ-040 HTRANS=BUSY and HSEL=0 cycles interleaved -> HREADYOUT stays 1, HRESP=0, memory unchanged.

Source files
------------

// File: rtl/ahb_ws_ram.sv
// AHB-Lite RAM slave: fixed wait states per OKAY transfer, two-cycle ERROR response
// for illegal size/alignment. Memory is never cleared by reset.
module ahb_ws_ram #(
  parameter int AW = 10,
  parameter int WS = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

  localparam logic [2:0] WS_M1 = (WS > 0) ? 3'(WS - 1) : 3'd0;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;

  logic [31:0]   mem [2**AW];

  logic          can_take;
  logic          accept;
  logic          illegal;
  logic          mem_we;
  logic [3:0]    lane_en;
  logic [AW-1:0] widx;
  logic          addr_hi_unused;

  assign addr_hi_unused = ^HADDR[31:AW+2];

  // New address phases are only taken when the current data phase is finishing or idle.
  assign can_take = (state_q == IDLE) || (state_q == LAST) || (state_q == ERR2);
  assign accept   = can_take & HSEL & HREADY & HTRANS[1];
  assign illegal  = (HSIZE > 3'd2)
                  || ((HSIZE == 3'd1) && HADDR[0])
                  || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 3'd0) state_d = LAST;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ERR2;
      end
      ERR2:    HRESP = 1'b1;
      default: ;
    endcase
    if (can_take) begin
      if (!accept) begin
        state_d = IDLE;
      end else if (illegal) begin
        state_d = ERR1;
      end else if (WS > 0) begin
        state_d = WAIT;
        cnt_d   = WS_M1;
      end else begin
        state_d = LAST;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= HADDR[AW+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  assign widx   = addr_q[AW+1:2];
  assign mem_we = (state_q == LAST) && write_q;

  always_comb begin
    case (size_q)
      3'd0:    lane_en = 4'b0001 << addr_q[1:0];
      3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[widx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // A write lands at the end of its LAST cycle, so a following read sees it without stalling.
  assign HRDATA = ((state_q == LAST) && !write_q) ? mem[widx] : 32'h0;

endmodule

// File: tb/tb_ahb_ws_ram.sv
// Bench for ahb_ws_ram: three instances (WS = 0, 1, 2), one active at a time, driven
// by a pipelined master and checked every cycle against a transaction-level model.
module tb_ahb_ws_ram;
  localparam int AWT = 5;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ap_t;

  logic        clk;
  logic        rst_n;
  logic        hsel_b;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic [31:0] hwdata;
  logic [2:0]  hsel_v;
  logic [2:0]  hrdyo;
  logic [2:0]  hrespo;
  logic [31:0] hrd [3];

  int          cur_k;
  logic        chk_on;
  exp_t        exp_q[$];
  logic [31:0] mm [3][2**AWT];
  logic [31:0] last_rd;
  int          n_stall;
  int          n_err;
  int          n_chk;
  int          n_pass;

  // Instance g is built with g wait states.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign hsel_v[g] = hsel_b && (cur_k == g);
    ahb_ws_ram #(.AW(AWT), .WS(g)) u_dut (
      .HCLK     (clk),
      .HRESETn  (rst_n),
      .HSEL     (hsel_v[g]),
      .HADDR    (haddr),
      .HTRANS   (htrans),
      .HWRITE   (hwrite),
      .HSIZE    (hsize),
      .HREADY   (hready),
      .HWDATA   (hwdata),
      .HRDATA   (hrd[g]),
      .HREADYOUT(hrdyo[g]),
      .HRESP    (hrespo[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t, inst %0d)", nm, act, exp, $time, cur_k);
  endtask

  function automatic exp_t mk_e(logic rdy, logic resp, logic rd, logic [31:0] data);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.rd = rd; e.data = data;
    return e;
  endfunction

  function automatic ap_t mk_ap(logic sel, logic [1:0] trans, logic wr, logic [2:0] size,
                                logic [31:0] addr, logic [31:0] wdata);
    ap_t a;
    a.sel = sel; a.trans = trans; a.wr = wr; a.size = size; a.addr = addr; a.wdata = wdata;
    return a;
  endfunction

  function automatic logic legal(ap_t a);
    return (a.size <= 3'd2) && !((a.size == 3'd1) && a.addr[0])
        && !((a.size == 3'd2) && (a.addr[1:0] != 2'b00));
  endfunction

  // Transaction-level model: queue the expected outputs of every data-phase cycle.
  task automatic model_push(input ap_t a);
    int idx;
    logic hit;
    idx = int'(a.addr[AWT+1:2]);
    if (!(a.sel && a.trans[1])) begin
      exp_q.push_back(mk_e(1'b1, 1'b0, 1'b0, 32'h0));
    end else if (!legal(a)) begin
      exp_q.push_back(mk_e(1'b0, 1'b1, 1'b0, 32'h0));
      exp_q.push_back(mk_e(1'b1, 1'b1, 1'b0, 32'h0));
    end else begin
      repeat (cur_k) exp_q.push_back(mk_e(1'b0, 1'b0, 1'b0, 32'h0));
      if (a.wr) begin
        for (int b = 0; b < 4; b++) begin
          hit = (a.size == 3'd2) || ((a.size == 3'd1) && ((b / 2) == int'(a.addr[1])))
             || ((a.size == 3'd0) && (b == int'(a.addr[1:0])));
          if (hit) mm[cur_k][idx][8*b +: 8] = a.wdata[8*b +: 8];
        end
        exp_q.push_back(mk_e(1'b1, 1'b0, 1'b0, 32'h0));
      end else begin
        exp_q.push_back(mk_e(1'b1, 1'b0, 1'b1, mm[cur_k][idx]));
      end
    end
  endtask

  // Called at posedge+1 when the current cycle ends a data phase (or is idle).
  task automatic offer(input ap_t a);
    hsel_b = a.sel; htrans = a.trans; hwrite = a.wr; hsize = a.size; haddr = a.addr;
    hready = 1'b1;
    model_push(a);
    @(posedge clk); #1;
    hwdata = a.wr ? a.wdata : $urandom();
    while (exp_q.size() > 0 && !exp_q[0].rdy) begin
      hready = 1'b0;
      hsel_b = 1'($urandom_range(0, 1));
      htrans = 2'($urandom_range(0, 3));
      hwrite = 1'($urandom_range(0, 1));
      hsize  = 3'($urandom_range(0, 2));
      haddr  = $urandom();
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] d);
    offer(mk_ap(1'b1, 2'd2, 1'b1, size, addr, d));
  endtask

  task automatic rd(input logic [31:0] addr);
    offer(mk_ap(1'b1, 2'd2, 1'b0, 3'd2, addr, 32'h0));
  endtask

  task automatic idle();
    offer(mk_ap(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0));
  endtask

  task automatic rand_offer();
    ap_t a;
    a.sel   = ($urandom_range(0, 7) != 0);
    a.trans = 2'($urandom_range(0, 3));
    a.wr    = 1'($urandom_range(0, 1));
    a.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    a.addr  = $urandom();
    a.wdata = $urandom();
    offer(a);
  endtask

  task automatic preload();
    for (int w = 0; w < 2**AWT; w++) wr(3'd2, 32'(w * 4), $urandom());
    idle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        if (k != cur_k) check("idle_other", {30'h0, hrdyo[k], hrespo[k], hrd[k]}, {30'h0, 1'b1, 1'b0, 32'h0});
      end
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL exp_underflow: no expected entry at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("dphase", {30'h0, hrdyo[cur_k], hrespo[cur_k], hrd[cur_k]}, {30'h0, e.rdy, e.resp, e.data});
        if (e.rd) last_rd = hrd[cur_k];
      end
      if (!hrdyo[cur_k]) n_stall++;
      if (hrespo[cur_k]) n_err++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; n_stall = 0; n_err = 0; last_rd = '0;
    chk_on = 1'b0; cur_k = 0; rst_n = 1'b0;
    hsel_b = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; haddr = '0; hwdata = '0; hready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("reset_out", {30'h0, hrdyo[k], hrespo[k], hrd[k]}, {30'h0, 1'b1, 1'b0, 32'h0});
    rst_n = 1'b1;
    exp_q.push_back(mk_e(1'b1, 1'b0, 1'b0, 32'h0));
    chk_on = 1'b1;

    // WS=0: lane merging without stalls, then an illegal halfword.
    cur_k = 0;
    preload();
    n_stall = 0;
    wr(3'd2, 32'h20, 32'h11223344);
    wr(3'd0, 32'h21, 32'hFFFFAAFF);
    wr(3'd1, 32'h22, 32'h5566EEEE);
    rd(32'h20);
    idle();
    check("ws0_lanes_rd", {32'h0, last_rd}, {32'h0, 32'h5566AA44});
    check("ws0_lanes_model", {32'h0, mm[0][8]}, {32'h0, 32'h5566AA44});
    check("ws0_no_stall", 64'(n_stall), 64'd0);
    wr(3'd2, 32'h00, 32'h01020304);
    idle();
    n_err = 0;
    wr(3'd1, 32'h03, 32'hFFFFFFFF);
    rd(32'h00);
    idle();
    check("err_cycles", 64'(n_err), 64'd2);
    check("err_no_write", {32'h0, last_rd}, {32'h0, 32'h01020304});
    repeat (300) rand_offer();
    idle();

    // WS=1: basic write/read, BUSY and deselected cycles, address aliasing.
    cur_k = 1;
    preload();
    n_stall = 0;
    wr(3'd2, 32'h10, 32'hCAFEBABE);
    rd(32'h10);
    idle();
    check("ws1_rd", {32'h0, last_rd}, {32'h0, 32'hCAFEBABE});
    check("ws1_stalls", 64'(n_stall), 64'd2);
    wr(3'd2, 32'h50, 32'h13579BDF);
    n_stall = 0; n_err = 0;
    offer(mk_ap(1'b1, 2'd1, 1'b1, 3'd2, 32'h50, 32'hFFFFFFFF));
    offer(mk_ap(1'b0, 2'd2, 1'b1, 3'd2, 32'h50, 32'hFFFFFFFF));
    offer(mk_ap(1'b1, 2'd0, 1'b1, 3'd2, 32'h50, 32'hFFFFFFFF));
    offer(mk_ap(1'b0, 2'd3, 1'b1, 3'd2, 32'h50, 32'hFFFFFFFF));
    check("busy_desel_ready", 64'(n_stall + n_err), 64'd0);
    rd(32'h50);
    idle();
    check("busy_desel_mem", {32'h0, last_rd}, {32'h0, 32'h13579BDF});
    wr(3'd2, 32'hF000_0084, 32'h600D0001);
    rd(32'h0000_0004);
    idle();
    check("alias_rd", {32'h0, last_rd}, {32'h0, 32'h600D0001});
    repeat (300) rand_offer();
    idle();

    // WS=2: pipelined write->read, then reset in the middle of a write.
    cur_k = 2;
    preload();
    n_stall = 0;
    wr(3'd2, 32'h30, 32'h0BADF00D);
    rd(32'h30);
    idle();
    check("ws2_b2b_rd", {32'h0, last_rd}, {32'h0, 32'h0BADF00D});
    check("ws2_b2b_stalls", 64'(n_stall), 64'd4);
    wr(3'd2, 32'h40, 32'h0);
    idle();
    chk_on = 1'b0;
    exp_q.delete();
    hsel_b = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40; hready = 1'b1;
    @(posedge clk); #1;
    hsel_b = 1'b0; htrans = 2'd0; hready = 1'b0; hwdata = 32'hDEADBEEF;
    check("rst_in_wait", {63'h0, hrdyo[2]}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_immediate", {30'h0, hrdyo[2], hrespo[2], hrd[2]}, {30'h0, 1'b1, 1'b0, 32'h0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hready = 1'b1;
    exp_q.push_back(mk_e(1'b1, 1'b0, 1'b0, 32'h0));
    chk_on = 1'b1;
    rd(32'h40);
    idle();
    check("rst_no_write", {32'h0, last_rd}, {32'h0, 32'h0});
    repeat (300) rand_offer();
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
